alu_share_arb: RTL and testbench

Two-port arbiter that shares the single combinational ALU between two requesters: requester 0 is the main execute path and requester 1 is the branch/compare path. It accepts 4-bit ALU opcodes plus operands over valid/ready handshakes and grants round-robin. It runs one issue register that drives the ALU and one result register that returns the value to the owning requester. It sits between the ALU control unit outputs and the ALU, and adds two cycles of latency at a throughput of one operation per cycle.

---
 rtl/alu_share_arb.sv | 126 ++++++++++++
 tb/tb_alu_share_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between two requesters.
// Requester 0 is the execute path, requester 1 the branch/compare path.
// Two register stages: S1 (issue, drives the ALU) and S2 (result, drives
// the response bus). Round-robin grant on ties, two cycles of latency,
// one operation per cycle when the owning response port keeps up.
//
// Handshake rules: a transfer happens on a rising edge where valid and
// ready are both high. Requesters hold valid and payload stable until
// ready. reqN_ready is combinational and may depend on rsp*_ready.
// rspN_valid holds with stable rsp_data until rspN_ready is seen high.
module alu_share_arb #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             alu_valid,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data
);

  // Issue stage
  logic             r_s1_valid;
  logic             r_s1_owner;
  logic [OPW-1:0]   r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  // Result stage
  logic             r_s2_valid;
  logic             r_s2_owner;
  logic [WIDTH-1:0] r_s2_data;
  // Requester granted on the most recent handshake
  logic             r_last_grant;

  logic w_s2_free;
  logic w_s1_free;
  logic w_s1_move;
  logic w_grant0;
  logic w_grant1;
  logic w_hs0;
  logic w_hs1;

  // Stage occupancy, round-robin arbitration and handshake detection
  always_comb begin
    w_s2_free = !r_s2_valid || (r_s2_owner ? rsp1_ready : rsp0_ready);
    w_s1_free = !r_s1_valid || w_s2_free;
    w_s1_move = r_s1_valid && w_s2_free;
    // On a tie the requester that did not win last time is granted
    w_grant0  = req0_valid && (!req1_valid || r_last_grant);
    w_grant1  = req1_valid && (!req0_valid || !r_last_grant);
    w_hs0     = w_s1_free && w_grant0;
    w_hs1     = w_s1_free && w_grant1;
  end

  assign req0_ready = w_hs0;
  assign req1_ready = w_hs1;

  // S1: load on a handshake, empty when the op moves on without a refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_owner   <= 1'b0;
      r_s1_op      <= '0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_last_grant <= 1'b1;
    end else if (w_hs0) begin
      r_s1_valid   <= 1'b1;
      r_s1_owner   <= 1'b0;
      r_s1_op      <= req0_op;
      r_s1_a       <= req0_a;
      r_s1_b       <= req0_b;
      r_last_grant <= 1'b0;
    end else if (w_hs1) begin
      r_s1_valid   <= 1'b1;
      r_s1_owner   <= 1'b1;
      r_s1_op      <= req1_op;
      r_s1_a       <= req1_a;
      r_s1_b       <= req1_b;
      r_last_grant <= 1'b1;
    end else if (w_s1_move) begin
      r_s1_valid   <= 1'b0;
    end
  end

  // S2: capture the ALU result when S1 advances, empty when drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_owner <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s1_move) begin
      r_s2_valid <= 1'b1;
      r_s2_owner <= r_s1_owner;
      r_s2_data  <= alu_result;
    end else if (w_s2_free) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign alu_valid  = r_s1_valid;
  assign alu_op     = r_s1_op;
  assign alu_a      = r_s1_a;
  assign alu_b      = r_s1_b;
  assign rsp0_valid = r_s2_valid && !r_s2_owner;
  assign rsp1_valid = r_s2_valid && r_s2_owner;
  assign rsp_data   = r_s2_data;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed stimulus against alu_share_arb with a
// behavioural ALU and an ordered scoreboard of {owner, result}.
module tb_alu_share_arb;
  localparam int WIDTH = 32;
  localparam int OPW   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [OPW-1:0]   req0_op = '0, req1_op = '0;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             alu_valid;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [WIDTH-1:0] rsp_data;

  int checks = 0;
  int failures = 0;
  logic [WIDTH:0] exp_q[$];
  logic exp_last = 1'b1;

  alu_share_arb #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data)
  );

  // Clock
  always #5 clk = ~clk;

  // Behavioural ALU
  function automatic logic [WIDTH-1:0] alu_model(input logic [OPW-1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_model(alu_op, alu_a, alu_b);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every accepted response against the queue head
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (rsp0_valid && rsp1_valid) chk("rsp_both_valid", 1, 0);
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", {31'd0, rsp1_valid, rsp_data}, 64'h1_0000_0000_0000);
        end else begin
          chk("rsp_owner_data", {31'd0, rsp1_valid, rsp_data}, {31'd0, exp_q[0]});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Reset in mid-cycle; in-flight work is discarded
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_rsp_data", rsp_data, 0);
    exp_q.delete();
    exp_last = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One cycle of request driving; exp_free is whether S1 should accept
  task automatic step(input logic v0, input logic [OPW-1:0] op0,
                      input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                      input logic v1, input logic [OPW-1:0] op1,
                      input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                      input logic rr0, input logic rr1, input logic exp_free,
                      output logic acc0, output logic acc1);
    logic eg0, eg1;
    @(negedge clk);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp0_ready = rr0; rsp1_ready = rr1;
    eg0 = v0 && (!v1 || exp_last);
    eg1 = v1 && (!v0 || !exp_last);
    acc0 = exp_free && eg0;
    acc1 = exp_free && eg1;
    #1;
    chk("req0_ready", req0_ready, acc0);
    chk("req1_ready", req1_ready, acc1);
    if (acc0) begin exp_q.push_back({1'b0, alu_model(op0, a0, b0)}); exp_last = 1'b0; end
    if (acc1) begin exp_q.push_back({1'b1, alu_model(op1, a1, b1)}); exp_last = 1'b1; end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc0, acc1;
    int i, j, n;

    do_reset();

    // Single ADD from requester 0: 2-cycle latency
    step(1, 4'd0, 32'd5, 32'd7, 0, 4'd0, 0, 0, 1, 1, 1, acc0, acc1);
    chk("t1_alu_valid", alu_valid, 1);
    chk("t1_alu_op", alu_op, 0);
    chk("t1_alu_a", alu_a, 5);
    chk("t1_alu_b", alu_b, 7);
    chk("t1_rsp0_early", rsp0_valid, 0);
    wait_cycles(1);
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_rsp1_valid", rsp1_valid, 0);
    chk("t1_rsp_data", rsp_data, 12);
    wait_cycles(2);
    chk("t1_rsp0_idle", rsp0_valid, 0);

    // Both requesters streaming: grants alternate 0,1,0,1
    do_reset();
    i = 0; j = 0; n = 0;
    while ((i < 4 || j < 4) && n < 20) begin
      step(i < 4, 4'd0, 32'(1 + i), 0, j < 4, 4'd0, 32'(101 + j), 0, 1, 1, 1, acc0, acc1);
      if (acc0) i++;
      if (acc1) j++;
      n++;
    end
    chk("t2_cycles", n, 8);
    wait_cycles(3);
    chk("t2_drained", exp_q.size(), 0);

    // Requester 1 alone three times, then requester 0 wins the tie
    do_reset();
    step(0, 4'd0, 0, 0, 1, 4'd1, 32'd50, 32'd8, 1, 1, 1, acc0, acc1);
    step(0, 4'd0, 0, 0, 1, 4'd4, 32'hF0F0, 32'h0FF0, 1, 1, 1, acc0, acc1);
    step(0, 4'd0, 0, 0, 1, 4'd2, 32'hFF00, 32'h0F0F, 1, 1, 1, acc0, acc1);
    step(1, 4'd3, 32'h10, 32'h01, 1, 4'd0, 32'd9, 32'd9, 1, 1, 1, acc0, acc1);
    step(1, 4'd0, 32'd3, 32'd4, 1, 4'd0, 32'd9, 32'd9, 1, 1, 1, acc0, acc1);
    step(1, 4'd0, 32'd3, 32'd4, 0, 4'd0, 0, 0, 1, 1, 1, acc0, acc1);
    wait_cycles(3);
    chk("t3_drained", exp_q.size(), 0);

    // Backpressure on rsp0 while requester 0 streams
    step(1, 4'd0, 32'd11, 32'd1, 0, 4'd0, 0, 0, 0, 1, 1, acc0, acc1);
    step(1, 4'd0, 32'd12, 32'd1, 0, 4'd0, 0, 0, 0, 1, 1, acc0, acc1);
    step(1, 4'd0, 32'd13, 32'd1, 0, 4'd0, 0, 0, 0, 1, 0, acc0, acc1);
    chk("t4_rsp0_hold", rsp0_valid, 1);
    chk("t4_data_hold", rsp_data, 12);
    chk("t4_s1_full", alu_valid, 1);
    chk("t4_s1_a", alu_a, 12);
    step(1, 4'd0, 32'd13, 32'd1, 0, 4'd0, 0, 0, 0, 1, 0, acc0, acc1);
    chk("t4_rsp0_hold2", rsp0_valid, 1);
    chk("t4_data_hold2", rsp_data, 12);
    step(1, 4'd0, 32'd13, 32'd1, 0, 4'd0, 0, 0, 1, 1, 1, acc0, acc1);
    step(1, 4'd0, 32'd14, 32'd1, 0, 4'd0, 0, 0, 1, 1, 1, acc0, acc1);
    wait_cycles(3);
    chk("t4_drained", exp_q.size(), 0);

    // Reset with both stages full
    step(1, 4'd0, 32'd21, 32'd1, 0, 4'd0, 0, 0, 0, 1, 1, acc0, acc1);
    step(1, 4'd0, 32'd22, 32'd1, 0, 4'd0, 0, 0, 0, 1, 1, acc0, acc1);
    chk("t5_s1_full", alu_valid, 1);
    chk("t5_s2_full", rsp0_valid, 1);
    do_reset();
    rsp0_ready = 1'b1;
    wait_cycles(3);
    step(1, 4'd0, 32'd31, 32'd2, 1, 4'd1, 32'd40, 32'd1, 1, 1, 1, acc0, acc1);
    step(0, 4'd0, 0, 0, 1, 4'd1, 32'd40, 32'd1, 1, 1, 1, acc0, acc1);
    wait_cycles(3);
    chk("t5_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
